// File: rtl/arbitro_multipli_pkg.sv
// Shared types and default sizing for the arbitro_multipli multiplier-sharing arbiter.
package arbitro_multipli_pkg;

    localparam int DEF_TAMANO  = 8;
    localparam int DEF_NREQ    = 4;
    localparam int DEF_TIMEOUT = 64;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RELEASE = 2'd2
    } state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin selector: first asserted request at or after the pointer, wrapping.
module rr_picker #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_ptr,
    output logic            o_found,
    output logic [IW-1:0]   o_idx
);

    localparam logic [IW:0] NREQ_W = (IW+1)'(NREQ);

    logic [IW:0]   w_sum;
    logic [IW-1:0] w_pos;

    // Scan offsets from farthest to nearest so the nearest asserted request is the last one written
    always_comb begin
        o_found = 1'b0;
        o_idx   = {IW{1'b0}};
        w_sum   = {(IW+1){1'b0}};
        w_pos   = {IW{1'b0}};
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_sum = {1'b0, i_ptr} + (IW+1)'(k);
            if (w_sum >= NREQ_W) begin
                w_pos = IW'(w_sum - NREQ_W);
            end else begin
                w_pos = w_sum[IW-1:0];
            end
            if (i_req[w_pos]) begin
                o_found = 1'b1;
                o_idx   = w_pos;
            end else begin
                o_found = o_found;
            end
        end
    end

endmodule

// File: rtl/arbitro_multipli.sv
// Round-robin arbiter/sequencer sharing one multipli instance among NREQ requesters, with watchdog.
module arbitro_multipli
    import arbitro_multipli_pkg::*;
#(
    parameter int tamano  = DEF_TAMANO,
    parameter int NREQ    = DEF_NREQ,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                          CLOCK,
    input  logic                          RESET,
    input  logic [NREQ-1:0]               REQ,
    input  logic [NREQ*tamano-1:0]        A_IN,
    input  logic [NREQ*tamano-1:0]        B_IN,
    output logic [NREQ-1:0]               ACK,
    output logic                          ERR,
    output logic [2*tamano-1:0]           S_OUT,
    output logic [$clog2(NREQ)-1:0]       GRANT_ID,
    output logic                          BUSY,
    output logic                          M_START,
    output logic [tamano-1:0]             M_A,
    output logic [tamano-1:0]             M_B,
    input  logic                          M_END,
    input  logic [2*tamano-1:0]           M_S
);

    localparam int IW = $clog2(NREQ);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);
    localparam logic [IW-1:0] LAST_ID = IW'(NREQ - 1);

    state_t              r_state, w_state_nx;
    logic [IW-1:0]       r_ptr, w_ptr_nx;
    logic [WW-1:0]       r_wd, w_wd_nx;
    logic [NREQ-1:0]     r_ack, w_ack_nx;
    logic                r_err, w_err_nx;
    logic [2*tamano-1:0] r_s, w_s_nx;
    logic [IW-1:0]       r_grant, w_grant_nx;
    logic                r_busy, w_busy_nx;
    logic                r_start, w_start_nx;
    logic [tamano-1:0]   r_a, w_a_nx;
    logic [tamano-1:0]   r_b, w_b_nx;
    logic                w_found;
    logic [IW-1:0]       w_pick;

    rr_picker #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_picker (
        .i_req   (REQ),
        .i_ptr   (r_ptr),
        .o_found (w_found),
        .o_idx   (w_pick)
    );

    // Next-state and next-output logic; ACK/ERR default low so they are single-cycle pulses
    always_comb begin
        w_state_nx = r_state;
        w_ptr_nx   = r_ptr;
        w_wd_nx    = r_wd;
        w_ack_nx   = {NREQ{1'b0}};
        w_err_nx   = 1'b0;
        w_s_nx     = r_s;
        w_grant_nx = r_grant;
        w_start_nx = r_start;
        w_a_nx     = r_a;
        w_b_nx     = r_b;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_grant_nx = w_pick;
                    w_a_nx     = A_IN[w_pick*tamano +: tamano];
                    w_b_nx     = B_IN[w_pick*tamano +: tamano];
                    w_start_nx = 1'b1;
                    w_ptr_nx   = (w_pick == LAST_ID) ? {IW{1'b0}} : w_pick + IW'(1);
                    w_wd_nx    = {WW{1'b0}};
                    w_state_nx = ISSUE;
                end else begin
                    w_state_nx = IDLE;
                end
            end
            ISSUE: begin
                if (M_END) begin
                    w_s_nx            = M_S;
                    w_ack_nx[r_grant] = 1'b1;
                    w_start_nx        = 1'b0;
                    w_state_nx        = RELEASE;
                end else if (r_wd == WD_LAST) begin
                    w_s_nx            = {(2*tamano){1'b0}};
                    w_ack_nx[r_grant] = 1'b1;
                    w_err_nx          = 1'b1;
                    w_start_nx        = 1'b0;
                    w_state_nx        = RELEASE;
                end else begin
                    w_wd_nx = r_wd + WW'(1);
                end
            end
            RELEASE: begin
                // Wait for END_MULT to drop so a stale completion cannot finish the next job
                if (!M_END) begin
                    w_state_nx = IDLE;
                end else begin
                    w_state_nx = RELEASE;
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
        w_busy_nx = (w_state_nx != IDLE);
    end

    // State and registered outputs
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_state <= IDLE;
            r_ptr   <= {IW{1'b0}};
            r_wd    <= {WW{1'b0}};
            r_ack   <= {NREQ{1'b0}};
            r_err   <= 1'b0;
            r_s     <= {(2*tamano){1'b0}};
            r_grant <= {IW{1'b0}};
            r_busy  <= 1'b0;
            r_start <= 1'b0;
            r_a     <= {tamano{1'b0}};
            r_b     <= {tamano{1'b0}};
        end else begin
            r_state <= w_state_nx;
            r_ptr   <= w_ptr_nx;
            r_wd    <= w_wd_nx;
            r_ack   <= w_ack_nx;
            r_err   <= w_err_nx;
            r_s     <= w_s_nx;
            r_grant <= w_grant_nx;
            r_busy  <= w_busy_nx;
            r_start <= w_start_nx;
            r_a     <= w_a_nx;
            r_b     <= w_b_nx;
        end
    end

    assign ACK      = r_ack;
    assign ERR      = r_err;
    assign S_OUT    = r_s;
    assign GRANT_ID = r_grant;
    assign BUSY     = r_busy;
    assign M_START  = r_start;
    assign M_A      = r_a;
    assign M_B      = r_b;

endmodule

// File: tb/tb_arbitro_multipli.sv
// Self-checking bench: multiplier stub with configurable latency/hang/stale END, round-robin reference model.
module tb_arbitro_multipli;

    localparam int TAM = 8;
    localparam int NR  = 4;
    localparam int TO  = 64;

    logic                CLOCK = 1'b0;
    logic                RESET;
    logic [NR-1:0]       REQ;
    logic [NR*TAM-1:0]   A_IN;
    logic [NR*TAM-1:0]   B_IN;
    logic [NR-1:0]       ACK;
    logic                ERR;
    logic [2*TAM-1:0]    S_OUT;
    logic [1:0]          GRANT_ID;
    logic                BUSY;
    logic                M_START;
    logic [TAM-1:0]      M_A;
    logic [TAM-1:0]      M_B;
    logic                M_END;
    logic [2*TAM-1:0]    M_S;

    arbitro_multipli #(.tamano(TAM), .NREQ(NR), .TIMEOUT(TO)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .REQ(REQ), .A_IN(A_IN), .B_IN(B_IN),
        .ACK(ACK), .ERR(ERR), .S_OUT(S_OUT), .GRANT_ID(GRANT_ID), .BUSY(BUSY),
        .M_START(M_START), .M_A(M_A), .M_B(M_B), .M_END(M_END), .M_S(M_S)
    );

    always #5 CLOCK = ~CLOCK;

    // Multiplier stub behaviour knobs, set from the stimulus block
    int lat   = 2;
    int stale = 0;
    bit hung  = 1'b0;
    int cnt;
    int hold;

    // Multiplier stub: END after lat cycles of START, held until START drops plus stale extra cycles
    always @(posedge CLOCK) begin
        if (RESET) begin
            M_END <= 1'b0;
            M_S   <= 16'd0;
            cnt   <= 0;
            hold  <= 0;
        end else if (M_START && !M_END) begin
            if (!hung && (cnt + 1 >= lat)) begin
                M_END <= 1'b1;
                M_S   <= M_A * M_B;
                hold  <= stale;
            end else begin
                cnt <= cnt + 1;
                M_S <= 16'($urandom);
            end
        end else if (!M_START) begin
            cnt <= 0;
            if (M_END) begin
                if (hold == 0) M_END <= 1'b0;
                else hold <= hold - 1;
            end
        end
    end

    int n_vec = 0;
    int n_err = 0;
    bit       req_v [NR];
    logic [7:0] a_v [NR];
    logic [7:0] b_v [NR];
    int ptr_m = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            REQ[i]               = req_v[i];
            A_IN[i*TAM +: TAM]   = a_v[i];
            B_IN[i*TAM +: TAM]   = b_v[i];
        end
    endtask

    function automatic int winner();
        for (int k = 0; k < NR; k++) begin
            if (req_v[(ptr_m + k) % NR]) return (ptr_m + k) % NR;
        end
        return 0;
    endfunction

    task automatic do_reset();
        @(negedge CLOCK);
        RESET = 1'b1;
        @(negedge CLOCK);
        RESET = 1'b0;
        ptr_m = 0;
    endtask

    // Serve one job: wait for grant, check operands, then the ACK pulse, product and latency
    task automatic serve(output int g);
        int cyc;
        bit seen;
        logic [15:0] exp_s;
        g     = winner();
        exp_s = hung ? 16'd0 : 16'(a_v[g]) * 16'(b_v[g]);
        seen  = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge CLOCK);
            if (M_START) seen = 1'b1;
        end
        chk("start_rise", 32'(seen), 32'd1);
        if (seen) begin
            chk("grant_id", 32'(GRANT_ID), 32'(g));
            chk("m_a", 32'(M_A), 32'(a_v[g]));
            chk("m_b", 32'(M_B), 32'(b_v[g]));
            chk("busy_issue", 32'(BUSY), 32'd1);
            cyc  = 0;
            seen = 1'b0;
            while (!seen && cyc < (hung ? TO + 10 : lat + 10)) begin
                @(negedge CLOCK);
                cyc++;
                if (ACK != '0) seen = 1'b1;
            end
            chk("ack_seen", 32'(seen), 32'd1);
            chk("latency", 32'(cyc), hung ? 32'(TO) : 32'(lat + 1));
            chk("ack_onehot", 32'(ACK), 32'd1 << g);
            chk("s_out", 32'(S_OUT), 32'(exp_s));
            chk("err", 32'(ERR), 32'(hung));
            chk("grant_at_ack", 32'(GRANT_ID), 32'(g));
            @(negedge CLOCK);
            chk("ack_pulse", 32'(ACK), 32'd0);
            chk("err_pulse", 32'(ERR), 32'd0);
            chk("start_low", 32'(M_START), 32'd0);
            if (hung) chk("busy_fall", 32'(BUSY), 32'd0);
        end
        ptr_m = (g + 1) % NR;
    endtask

    initial begin
        int g;
        int any;
        RESET = 1'b1;
        for (int i = 0; i < NR; i++) begin
            req_v[i] = 1'b0;
            a_v[i]   = 8'd0;
            b_v[i]   = 8'd0;
        end
        drive();
        repeat (2) @(negedge CLOCK);
        RESET = 1'b0;
        chk("rst_ack", 32'(ACK), 32'd0);
        chk("rst_err", 32'(ERR), 32'd0);
        chk("rst_s", 32'(S_OUT), 32'd0);
        chk("rst_grant", 32'(GRANT_ID), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_start", 32'(M_START), 32'd0);
        chk("rst_ma", 32'(M_A), 32'd0);
        chk("rst_mb", 32'(M_B), 32'd0);

        // 100 x 2 on requester 0
        req_v[0] = 1'b1; a_v[0] = 8'd100; b_v[0] = 8'd2; lat = 3; drive();
        serve(g);
        req_v[g] = 1'b0; drive();

        // Simultaneous 0 and 2 right after reset
        do_reset();
        req_v[0] = 1'b1; a_v[0] = 8'd10; b_v[0] = 8'd3;
        req_v[2] = 1'b1; a_v[2] = 8'd7;  b_v[2] = 8'd5; lat = 2; drive();
        repeat (2) begin
            serve(g);
            req_v[g] = 1'b0; drive();
        end

        // Largest operands on requester 3
        req_v[3] = 1'b1; a_v[3] = 8'd255; b_v[3] = 8'd255; lat = 5; drive();
        serve(g);
        req_v[g] = 1'b0; drive();

        // All four held: strict rotation
        for (int i = 0; i < NR; i++) begin
            req_v[i] = 1'b1; a_v[i] = 8'($urandom); b_v[i] = 8'($urandom);
        end
        drive();
        repeat (8) begin
            serve(g);
            a_v[g] = 8'($urandom); b_v[g] = 8'($urandom); lat = $urandom_range(6, 1); drive();
        end
        for (int i = 0; i < NR; i++) req_v[i] = 1'b0;
        drive();

        // Hung multiplier: watchdog expiry
        hung = 1'b1; req_v[1] = 1'b1; a_v[1] = 8'd9; b_v[1] = 8'd9; drive();
        serve(g);
        hung = 1'b0; req_v[g] = 1'b0; drive();

        // Reset while ISSUE is in flight
        hung = 1'b1; req_v[1] = 1'b1; a_v[1] = 8'd12; b_v[1] = 8'd11; drive();
        any = 0;
        for (int i = 0; i < 40 && any == 0; i++) begin
            @(negedge CLOCK);
            if (M_START) any = 1;
        end
        chk("mid_start", 32'(any), 32'd1);
        repeat (5) @(negedge CLOCK);
        RESET = 1'b1;
        @(negedge CLOCK);
        chk("abort_ack", 32'(ACK), 32'd0);
        chk("abort_err", 32'(ERR), 32'd0);
        chk("abort_s", 32'(S_OUT), 32'd0);
        chk("abort_grant", 32'(GRANT_ID), 32'd0);
        chk("abort_busy", 32'(BUSY), 32'd0);
        chk("abort_start", 32'(M_START), 32'd0);
        chk("abort_ma", 32'(M_A), 32'd0);
        RESET = 1'b0; hung = 1'b0; ptr_m = 0; lat = 2;
        req_v[3] = 1'b1; a_v[3] = 8'd4; b_v[3] = 8'd6; drive();
        serve(g);
        req_v[g] = 1'b0; drive();

        // Randomized traffic with re-requests and stale END_MULT
        repeat (40) begin
            if ($urandom_range(1, 0) == 0) req_v[g] = 1'b0;
            else begin
                a_v[g] = 8'($urandom); b_v[g] = 8'($urandom);
            end
            any = 0;
            for (int i = 0; i < NR; i++) begin
                if (!req_v[i] && $urandom_range(2, 0) == 0) begin
                    req_v[i] = 1'b1; a_v[i] = 8'($urandom); b_v[i] = 8'($urandom);
                end
                if (req_v[i]) any = 1;
            end
            if (any == 0) begin
                req_v[$urandom_range(NR-1, 0)] = 1'b1;
            end
            lat = $urandom_range(6, 1); stale = $urandom_range(3, 0);
            drive();
            serve(g);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
